// File: rtl/uio_rq_axi_arb_if.sv
// Bus bundle for the request arbiter: per-unit push side plus the single
// packet stream toward the user-IO request converter.
interface uio_rq_axi_arb_if #(
   parameter int N_PORTS         = 4,
   parameter int UIO_PORTS_WIDTH = 128
) ();
   localparam int PORT_W = $clog2(N_PORTS);

   logic [N_PORTS-1:0]                 i_rq_vld;
   logic [N_PORTS*UIO_PORTS_WIDTH-1:0] i_rq_data;
   logic [N_PORTS-1:0]                 o_rq_afull;
   logic [N_PORTS-1:0]                 o_rq_ovf;
   logic                               i_chan_up;
   logic                               o_uio_rq_vld;
   logic [UIO_PORTS_WIDTH-1:0]         o_uio_rq_data;
   logic                               o_uio_rq_last;
   logic [PORT_W-1:0]                  o_uio_rq_port;
   logic                               i_uio_rq_afull;

   modport slave (
      input  i_rq_vld, i_rq_data, i_chan_up, i_uio_rq_afull,
      output o_rq_afull, o_rq_ovf, o_uio_rq_vld, o_uio_rq_data,
             o_uio_rq_last, o_uio_rq_port
   );

   modport master (
      output i_rq_vld, i_rq_data, i_chan_up, i_uio_rq_afull,
      input  o_rq_afull, o_rq_ovf, o_uio_rq_vld, o_uio_rq_data,
             o_uio_rq_last, o_uio_rq_port
   );
endinterface

// File: rtl/uio_rq_axi_arb.sv
// Round-robin whole-packet arbiter: per-unit FWFT buffers feed one contiguous
// packet stream so frames from different units never interleave.
module uio_rq_axi_arb #(
   parameter int N_PORTS         = 4,
   parameter int UIO_PORTS_WIDTH = 128,
   parameter int PKT_WORDS       = 4,
   parameter int FIFO_DEPTH      = 16,
   parameter int AFULL_MARGIN    = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   uio_rq_axi_arb_if.slave bus
);
   localparam int PORT_W = $clog2(N_PORTS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BEAT_W = $clog2(PKT_WORDS);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   logic [N_PORTS-1:0]                      pop;
   logic [N_PORTS-1:0]                      elig;
   logic [N_PORTS-1:0]                      afull_vec;
   logic [N_PORTS-1:0]                      ovf_vec;
   logic [N_PORTS-1:0][UIO_PORTS_WIDTH-1:0] head;

   for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_fifo
      logic [UIO_PORTS_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]           cnt_q, cnt_d;
      logic                       afull_q, afull_d;
      logic                       ovf_q, ovf_d;
      logic                       push_ok;

      // A push into a full buffer still lands when the head leaves that cycle.
      always_comb begin
         push_ok  = bus.i_rq_vld[gi] && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop[gi]);
         wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop[gi]);
         cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop[gi]);
         afull_d  = (cnt_d >= CNT_W'(FIFO_DEPTH - AFULL_MARGIN));
         ovf_d    = ovf_q | (bus.i_rq_vld[gi] & ~push_ok);
      end

      always_ff @(posedge clk) begin
         if (push_ok) begin
            mem[wr_ptr_q] <= bus.i_rq_data[gi*UIO_PORTS_WIDTH +: UIO_PORTS_WIDTH];
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
         end
      end

      assign head[gi]      = mem[rd_ptr_q];
      assign elig[gi]      = (cnt_q >= CNT_W'(PKT_WORDS));
      assign afull_vec[gi] = afull_q;
      assign ovf_vec[gi]   = ovf_q;
   end

   state_t                     state_q, state_d;
   logic [PORT_W-1:0]          grant_q, grant_d;
   logic [PORT_W-1:0]          last_grant_q, last_grant_d;
   logic [BEAT_W-1:0]          beat_q, beat_d;
   logic                       vld_q, vld_d;
   logic [UIO_PORTS_WIDTH-1:0] data_q, data_d;
   logic                       last_q, last_d;
   logic [PORT_W-1:0]          port_q, port_d;

   logic                       found;
   logic [PORT_W-1:0]          pick;
   logic [PORT_W-1:0]          scan_idx;
   int                         scan_sum;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      vld_d        = 1'b0;
      data_d       = data_q;
      last_d       = 1'b0;
      port_d       = port_q;
      pop          = '0;
      found        = 1'b0;
      pick         = last_grant_q;
      scan_sum     = 0;
      scan_idx     = '0;

      // Search starts one past the previous winner so every unit gets a turn.
      for (int k = 1; k <= N_PORTS; k++) begin
         scan_sum = int'(last_grant_q) + k;
         if (scan_sum >= N_PORTS) scan_sum = scan_sum - N_PORTS;
         scan_idx = PORT_W'(scan_sum);
         if (!found && elig[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.i_chan_up && found && !bus.i_uio_rq_afull) begin
               grant_d = pick;
               beat_d  = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (!bus.i_uio_rq_afull) begin
               pop[grant_q] = 1'b1;
               vld_d        = 1'b1;
               data_d       = head[grant_q];
               port_d       = grant_q;
               last_d       = (beat_q == BEAT_W'(PKT_WORDS - 1));
               beat_d       = beat_q + 1'b1;
               if (beat_q == BEAT_W'(PKT_WORDS - 1)) begin
                  last_grant_d = grant_q;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= PORT_W'(N_PORTS - 1);
         beat_q       <= '0;
         vld_q        <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
         port_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
         vld_q        <= vld_d;
         data_q       <= data_d;
         last_q       <= last_d;
         port_q       <= port_d;
      end
   end

   assign bus.o_rq_afull    = afull_vec;
   assign bus.o_rq_ovf      = ovf_vec;
   assign bus.o_uio_rq_vld  = vld_q;
   assign bus.o_uio_rq_data = data_q;
   assign bus.o_uio_rq_last = last_q;
   assign bus.o_uio_rq_port = port_q;
endmodule

// File: tb/tb_uio_rq_axi_arb.sv
// Directed bench for uio_rq_axi_arb: a cycle-exact vector table for the first
// packet, then scoreboarded sequences for ordering, gating, stalls and reset.
`timescale 1ns/1ps
module tb_uio_rq_axi_arb;
   localparam int N = 4;
   localparam int W = 128;
   localparam int PKT = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   uio_rq_axi_arb_if #(.N_PORTS(N), .UIO_PORTS_WIDTH(W)) bus ();

   uio_rq_axi_arb #(
      .N_PORTS(N), .UIO_PORTS_WIDTH(W), .PKT_WORDS(PKT),
      .FIFO_DEPTH(16), .AFULL_MARGIN(6)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int seq_next [N];
   int exp_rd [N];
   int exp_ports [$];

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      logic [1:0]   port;
      int           cyc;
   } cap_t;
   cap_t cap [$];

   typedef struct {
      logic [N-1:0] vld;
      logic         exp_vld;
      logic         exp_last;
      logic [1:0]   exp_port;
      int           exp_seq;
   } vec_t;
   vec_t vecs [12];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n && bus.o_uio_rq_vld)
         cap.push_back('{bus.o_uio_rq_data, bus.o_uio_rq_last, bus.o_uio_rq_port, cyc});
   end

   function automatic logic [W-1:0] mkw(input int p, input int s);
      return {4{8'hA5, 8'(p), 16'(s)}};
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] mask);
      for (int p = 0; p < N; p++) begin
         bus.i_rq_data[p*W +: W] = mkw(p, seq_next[p]);
         if (mask[p]) seq_next[p]++;
      end
      bus.i_rq_vld = mask;
   endtask

   task automatic push_cycles(input logic [N-1:0] mask, input int n);
      repeat (n) begin
         @(negedge clk);
         drive(mask);
      end
      @(negedge clk);
      drive('0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_vld"}, W'(bus.o_uio_rq_vld), '0);
      chk({tag, "_data"}, bus.o_uio_rq_data, '0);
      chk({tag, "_last"}, W'(bus.o_uio_rq_last), '0);
      chk({tag, "_port"}, W'(bus.o_uio_rq_port), '0);
      chk({tag, "_afull"}, W'(bus.o_rq_afull), '0);
      chk({tag, "_ovf"}, W'(bus.o_rq_ovf), '0);
   endtask

   task automatic resync();
      for (int p = 0; p < N; p++) exp_rd[p] = seq_next[p];
      cap.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      drive('0);
      bus.i_chan_up = 1'b0;
      bus.i_uio_rq_afull = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      resync();
   endtask

   task automatic wait_words(input int n, input int budget);
      int t = 0;
      while (cap.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (cap.size() < n) begin
         total++;
         bad++;
         $display("FAIL wait_words: got %0d words expected %0d", cap.size(), n);
      end
   endtask

   // Compares the captured stream against the packet order in exp_ports.
   task automatic check_pkts(input bit gap);
      int n;
      int idx;
      int p;
      n = exp_ports.size() * PKT;
      wait_words(n, 200);
      repeat (8) @(negedge clk);
      chk("word_count", W'(cap.size()), W'(n));
      for (int j = 0; j < exp_ports.size(); j++) begin
         p = exp_ports[j];
         for (int k = 0; k < PKT; k++) begin
            idx = j*PKT + k;
            if (idx < cap.size()) begin
               chk("pkt_data", cap[idx].data, mkw(p, exp_rd[p]));
               chk("pkt_port", W'(cap[idx].port), W'(p));
               chk("pkt_last", W'(cap[idx].last), W'(k == PKT-1));
               if (gap && idx > 0)
                  chk("pkt_spacing", W'(cap[idx].cyc - cap[idx-1].cyc), W'((k == 0) ? 2 : 1));
            end
            exp_rd[p]++;
         end
      end
      cap.delete();
      exp_ports.delete();
   endtask

   task automatic wait_word(input int p, input int s, input int budget);
      int t = 0;
      while (!(bus.o_uio_rq_vld && bus.o_uio_rq_data == mkw(p, s)) && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("wait_word_seen", W'(bus.o_uio_rq_vld && bus.o_uio_rq_data == mkw(p, s)), W'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      for (int p = 0; p < N; p++) begin
         seq_next[p] = 0;
         exp_rd[p] = 0;
      end
      bus.i_rq_vld = '0;
      bus.i_rq_data = '0;
      bus.i_chan_up = 1'b0;
      bus.i_uio_rq_afull = 1'b0;

      // Single packet from port 0, cycle-exact vectors.
      do_reset();
      vecs[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 0};
      vecs[1]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 0};
      vecs[2]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 0};
      vecs[3]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 0};
      vecs[4]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 0};
      vecs[5]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 0};
      vecs[6]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 0};
      vecs[7]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1};
      vecs[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 2};
      vecs[9]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 3};
      vecs[10] = '{4'b0000, 1'b0, 1'b0, 2'd0, 0};
      vecs[11] = '{4'b0000, 1'b0, 1'b0, 2'd0, 0};
      base = seq_next[0];
      bus.i_chan_up = 1'b1;
      for (int r = 0; r < 12; r++) begin
         @(negedge clk);
         chk($sformatf("vec%0d_vld", r), W'(bus.o_uio_rq_vld), W'(vecs[r].exp_vld));
         chk($sformatf("vec%0d_last", r), W'(bus.o_uio_rq_last), W'(vecs[r].exp_last));
         chk($sformatf("vec%0d_afull", r), W'(bus.o_rq_afull), '0);
         if (vecs[r].exp_vld) begin
            chk($sformatf("vec%0d_port", r), W'(bus.o_uio_rq_port), W'(vecs[r].exp_port));
            chk($sformatf("vec%0d_data", r), bus.o_uio_rq_data, mkw(0, base + vecs[r].exp_seq));
         end
         drive(vecs[r].vld);
      end
      resync();

      // All four ports full at once: order 0,1,2,3 with one idle cycle between.
      do_reset();
      push_cycles(4'b1111, 4);
      bus.i_chan_up = 1'b1;
      exp_ports = '{0, 1, 2, 3};
      check_pkts(1'b1);
      push_cycles(4'b0011, 4);
      exp_ports = '{0, 1};
      check_pkts(1'b1);
      bus.i_chan_up = 1'b0;
      push_cycles(4'b1111, 4);
      bus.i_chan_up = 1'b1;
      exp_ports = '{2, 3, 0, 1};
      check_pkts(1'b1);

      // Partial packet on port 2 is never granted until complete.
      @(negedge clk); drive(4'b0110);
      @(negedge clk); drive(4'b0110);
      @(negedge clk); drive(4'b0110);
      @(negedge clk); drive(4'b0010);
      @(negedge clk); drive(4'b0000);
      exp_ports = '{1};
      check_pkts(1'b0);
      push_cycles(4'b0100, 1);
      exp_ports = '{2};
      check_pkts(1'b0);

      // Downstream stall of three cycles after beat 1.
      push_cycles(4'b0001, 4);
      wait_word(0, exp_rd[0] + 1, 50);
      bus.i_uio_rq_afull = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_vld", i), W'(bus.o_uio_rq_vld), '0);
      end
      bus.i_uio_rq_afull = 1'b0;
      @(negedge clk);
      chk("resume_b2_vld", W'(bus.o_uio_rq_vld), W'(1));
      chk("resume_b2_data", bus.o_uio_rq_data, mkw(0, exp_rd[0] + 2));
      chk("resume_b2_last", W'(bus.o_uio_rq_last), '0);
      @(negedge clk);
      chk("resume_b3_vld", W'(bus.o_uio_rq_vld), W'(1));
      chk("resume_b3_data", bus.o_uio_rq_data, mkw(0, exp_rd[0] + 3));
      chk("resume_b3_last", W'(bus.o_uio_rq_last), W'(1));
      exp_ports = '{0};
      check_pkts(1'b0);

      // Port 3 overfilled with the channel down: afull at 10, 17th push dropped.
      bus.i_chan_up = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         drive(4'b1000);
         @(negedge clk);
         drive(4'b0000);
         chk($sformatf("fill%0d_afull", k), W'(bus.o_rq_afull), W'((k >= 10) ? 4'b1000 : 4'b0000));
         chk($sformatf("fill%0d_ovf", k), W'(bus.o_rq_ovf), W'((k >= 17) ? 4'b1000 : 4'b0000));
      end
      bus.i_chan_up = 1'b1;
      exp_ports = '{3, 3, 3, 3};
      check_pkts(1'b1);
      chk("drain_ovf_sticky", W'(bus.o_rq_ovf), W'(4'b1000));
      chk("drain_afull", W'(bus.o_rq_afull), '0);
      resync();

      // Asynchronous reset mid-burst at beat 2.
      push_cycles(4'b0010, 4);
      wait_word(1, exp_rd[1] + 2, 50);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      resync();
      @(negedge clk); drive(4'b1011);
      @(negedge clk); drive(4'b1011);
      @(negedge clk); drive(4'b1011);
      @(negedge clk); drive(4'b1001);
      @(negedge clk); drive(4'b0000);
      exp_ports = '{0, 3};
      check_pkts(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uio_rq_axi_arb.md
Name: uio_rq_axi_arb

Overview:
- Round-robin packet arbiter sharing one user-IO request path, and therefore the AXI TX stream, among N_PORTS requesting units.
- Each unit pushes 128b words into a private buffer. The arbiter grants whole packets only: PKT_WORDS words, i.e. 512b/64B, one AXI tlast frame.
- It emits them contiguously toward the request converter, so frames from different units never interleave on AXI.
- Sits between the multiunit personality and the request side of the user-IO/AXI converter, all in the clk_per domain.

Parameters:
- N_PORTS, 4, number of requesting units (2..8).
- UIO_PORTS_WIDTH, 128, word width.
- PKT_WORDS, 4, words per packet (power of 2, ≥2).
- FIFO_DEPTH, 16, per-port buffer depth (power of 2, ≥2*PKT_WORDS).
- AFULL_MARGIN, 6, almost-full asserts at count ≥ FIFO_DEPTH-AFULL_MARGIN.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- i_rq_vld, input, N_PORTS, per-unit word push.
- i_rq_data, input, N_PORTS*UIO_PORTS_WIDTH, unit i word at [i*UIO_PORTS_WIDTH +: UIO_PORTS_WIDTH].
- o_rq_afull, output, N_PORTS, per-unit almost-full.
- o_rq_ovf, output, N_PORTS, sticky overflow (push dropped).
- i_chan_up, input, 1, channel up; new grants only when high.
- o_uio_rq_vld, output, 1, word valid toward converter.
- o_uio_rq_data, output, UIO_PORTS_WIDTH, word.
- o_uio_rq_last, output, 1, last word of packet.
- o_uio_rq_port, output, clog2(N_PORTS), source unit of current word.
- i_uio_rq_afull, input, 1, downstream almost-full (stall).

Behaviour:
- Reset, asynchronous on reset_n low:
  - All outputs 0.
  - FIFOs empty; state IDLE; beat counter 0.
  - last_grant = N_PORTS-1, so port 0 has first priority.
  - Sticky ovf cleared; it is cleared only by reset.
- Per-port FIFO, synchronous, first-word-fall-through read:
  - Push when i_rq_vld[i].
  - Push with cnt==FIFO_DEPTH and no same-cycle pop: word dropped, o_rq_ovf[i] set next cycle.
  - Push with same-cycle pop at full: accepted, cnt unchanged.
  - o_rq_afull[i] registered from next count: high when cnt ≥ FIFO_DEPTH-AFULL_MARGIN.
- Eligibility: elig[i] = cnt[i] ≥ PKT_WORDS. Partial packets are never granted.
- FSM, two states:
  - IDLE: if i_chan_up & |elig & !i_uio_rq_afull, grant = first eligible index scanning (last_grant+1) mod N_PORTS upward with wrap. Go to BURST, beat=0. Otherwise stay. No word is issued in IDLE.
  - BURST: each cycle with !i_uio_rq_afull:
    - Pop grant FIFO head.
    - Next cycle o_uio_rq_vld=1, o_uio_rq_data=head, o_uio_rq_port=grant, o_uio_rq_last=(beat==PKT_WORDS-1).
    - beat++.
    - On the beat==PKT_WORDS-1 pop: last_grant←grant, go IDLE.
  - BURST with i_uio_rq_afull high: no pop, o_uio_rq_vld=0 next cycle, beat held.
- Latency: grant decision in IDLE cycle T; first word popped T+1, visible on outputs T+2. Unstalled packet takes PKT_WORDS+1 cycles; sustained throughput PKT_WORDS/(PKT_WORDS+1).
- i_chan_up dropping mid-BURST: burst completes (frame integrity); gate applies only to new grants.
- Pushes to the granted port during its burst are allowed; count = cnt + push - pop.
- o_uio_rq_vld is a registered pulse with no ready handshake. Downstream must size afull margin ≥2 words (one pipeline word plus decision).
- Beat counter is clog2(PKT_WORDS) bits, wraps to 0 after the last beat.

Test Plan:
- Reset then port 0 pushes 4 words A0..A3, i_chan_up=1, afull=0: grant port 0; o_uio_rq_vld high 4 consecutive cycles starting 2 cycles after the 4th push registers. Data A0..A3, port=0, last only on A3.
- All 4 ports hold one full packet simultaneously: packets issued in port order 0,1,2,3, each 4 beats, one idle cycle between. Repeat with last_grant=1 and observe order 2,3,0,1.
- Port 2 holds 3 words only, port 1 holds 4: only port 1 granted. Port 2 granted after its 4th push; no partial packet ever issued.
- i_uio_rq_afull asserted for 3 cycles after beat 1 of a burst: exactly 3 cycles vld=0, beats 2,3 follow with no loss or duplication, last on beat 3.
- Port 3 pushes 17 words with no grant (i_chan_up=0): o_rq_afull[3] high at cnt 10, o_rq_ovf[3] set by the 17th push. First 16 words retained and issued in order once i_chan_up=1.
- reset_n pulsed low mid-burst (beat 2): outputs 0 immediately, FIFOs empty. After release, the next grant goes to port 0 first.
